// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the memory-access stage and a single-port data memory.
// One request in flight; accesses straddling an 8-byte line are split into several memory beats.
module lsu_mem_bridge (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]  state;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [63:0] lo_q;
  logic [63:0] hi_q;
  logic [2:0]  k_q;

  logic        accept;
  logic [2:0]  off;
  logic [3:0]  nbytes;
  logic [2:0]  last_k;
  logic        crossing;
  logic [63:0] base_addr;

  assign accept    = req_valid && req_ready;
  assign off       = addr_q[2:0];
  assign nbytes    = 4'd1 << size_q;
  assign last_k    = 3'(nbytes - 4'd1);
  assign crossing  = ({1'b0, off} + nbytes) > 4'd8;
  assign base_addr = {addr_q[63:3], 3'b000};

  // Buffers and counter are ordinary registers, so they are cleared along with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      k_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // based on pre-edge values, independent of statement order.
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            k_q      <= '0;
            state    <= req_we ? S_WR : S_RD0;
          end
        end
        S_RD0: begin
          lo_q  <= mem_rd_data;
          state <= crossing ? S_RD1 : S_RESP;
        end
        S_RD1: begin
          hi_q  <= mem_rd_data;
          state <= S_RESP;
        end
        S_WR: begin
          if (!crossing || (k_q == last_k)) begin
            state <= S_RESP;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load assembly: pick n bytes starting at the access offset out of {high, low}.
  logic [127:0] pair;
  logic [63:0]  raw;
  logic [63:0]  load_ext;
  logic [3:0]   idx;

  assign pair = {hi_q, lo_q};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    raw = '0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      idx = 4'({1'b0, off} + 4'(i));
      raw[8*i +: 8] = pair[{idx, 3'b000} +: 8];
    end
  end

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'd0:    load_ext = {{56{signed_q & raw[7]}},  raw[7:0]};
      2'd1:    load_ext = {{48{signed_q & raw[15]}}, raw[15:0]};
      2'd2:    load_ext = {{32{signed_q & raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  end

  logic [7:0] size_mask;

  always_comb begin
    size_mask = 8'h00;
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Outputs decode from state alone, so an asynchronous reset silences the memory at once.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_we_en   = 1'b0;
    mem_we_addr = '0;
    mem_we_data = '0;
    mem_we_mask = 8'h00;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_RD0: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_addr;
      end
      S_RD1: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_addr + 64'd8;
      end
      S_WR: begin
        mem_we_en = 1'b1;
        if (crossing) begin
          mem_we_addr = addr_q + {61'b0, k_q};
          mem_we_data = {56'b0, wdata_q[{k_q, 3'b000} +: 8]};
          mem_we_mask = 8'h01;
        end else begin
          mem_we_addr = addr_q;
          mem_we_data = wdata_q;
          mem_we_mask = size_mask;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? 64'd0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: byte-array memory model, reference image,
// and scoreboard queues for read beats, write beats and responses.
module tb_lsu_mem_bridge;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;

  lsu_mem_bridge dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_we_en   (mem_we_en),
    .mem_we_addr (mem_we_addr),
    .mem_we_data (mem_we_data),
    .mem_we_mask (mem_we_mask)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  beat_t       exp_we[$];
  logic [63:0] exp_rd[$];
  logic [63:0] exp_resp[$];
  int checks = 0;
  int errors = 0;

  // 256-byte memory indexed by the low address byte; the reference image mirrors it.
  logic [7:0] mem      [256];
  logic [7:0] ref_mem  [256];
  logic [7:0] init_img [256];
  logic       load_img = 1'b0;

  always_comb begin
    mem_rd_data = '0;
    for (int i = 0; i < 8; i++) mem_rd_data[8*i +: 8] = mem[8'(mem_rd_addr[7:0] + 8'(i))];
  end

  always @(posedge clock) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
    end else if (mem_we_en) begin
      for (int i = 0; i < 8; i++)
        if (mem_we_mask[i]) mem[8'(mem_we_addr[7:0] + 8'(i))] <= mem_we_data[8*i +: 8];
    end
  end

  // Monitor: compares every memory beat and response handshake against the scoreboard.
  always @(negedge clock) begin
    beat_t       eb;
    logic [63:0] ev;
    #1;
    if (reset_n) begin
      if (mem_we_en) begin
        checks++;
        if (exp_we.size() == 0) begin
          errors++;
          $display("FAIL we_beat unexpected: addr=%h data=%h mask=%h", mem_we_addr, mem_we_data, mem_we_mask);
        end else begin
          eb = exp_we.pop_front();
          if ({mem_we_addr, mem_we_data, mem_we_mask} !== eb) begin
            errors++;
            $display("FAIL we_beat: got addr=%h data=%h mask=%h want addr=%h data=%h mask=%h",
                     mem_we_addr, mem_we_data, mem_we_mask, eb.addr, eb.data, eb.mask);
          end
        end
      end else begin
        checks++;
        if ((mem_we_addr !== 64'd0) || (mem_we_data !== 64'd0) || (mem_we_mask !== 8'h00)) begin
          errors++;
          $display("FAIL we_idle_zero: addr=%h data=%h mask=%h want all 0", mem_we_addr, mem_we_data, mem_we_mask);
        end
      end
      if (mem_rd_en) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_beat unexpected: addr=%h", mem_rd_addr);
        end else begin
          ev = exp_rd.pop_front();
          if (mem_rd_addr !== ev) begin
            errors++;
            $display("FAIL rd_beat: got addr=%h want %h", mem_rd_addr, ev);
          end
        end
      end else begin
        checks++;
        if (mem_rd_addr !== 64'd0) begin
          errors++;
          $display("FAIL rd_idle_zero: addr=%h want 0", mem_rd_addr);
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp unexpected: rdata=%h", resp_rdata);
        end else begin
          ev = exp_resp.pop_front();
          if (resp_rdata !== ev) begin
            errors++;
            $display("FAIL resp_rdata: got %h want %h", resp_rdata, ev);
          end
        end
      end
    end
  end

  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] size, input logic sgn);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(addr[7:0] + 8'(i))];
    if (sgn && (size != 2'd3) && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [1:0] size, input logic sgn,
                        input logic [63:0] wdata, input logic bp, input logic has_exp, input logic [63:0] exp_val);
    int n, off, exp_lat, cnt;
    bit crossing;
    logic [63:0] held;
    logic [7:0] m;
    n        = 1 << size;
    off      = int'(addr[2:0]);
    crossing = (off + n) > 8;
    if (we) begin
      exp_lat = crossing ? n + 1 : 2;
      m = (size == 0) ? 8'h01 : (size == 1) ? 8'h03 : (size == 2) ? 8'h0F : 8'hFF;
      if (crossing) begin
        for (int k = 0; k < n; k++) exp_we.push_back({addr + 64'(k), {56'b0, wdata[8*k +: 8]}, 8'h01});
      end else begin
        exp_we.push_back({addr, wdata, m});
      end
      for (int k = 0; k < n; k++) ref_mem[8'(addr[7:0] + 8'(k))] = wdata[8*k +: 8];
      exp_resp.push_back(64'd0);
    end else begin
      exp_lat = crossing ? 3 : 2;
      exp_rd.push_back({addr[63:3], 3'b000});
      if (crossing) exp_rd.push_back({addr[63:3], 3'b000} + 64'd8);
      exp_resp.push_back(has_exp ? exp_val : model_load(addr, size, sgn));
    end

    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    resp_ready = !bp;

    @(negedge clock);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = {$urandom, $urandom};
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_wdata  = {$urandom, $urandom};
    cnt = 1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_ready_busy: got %b want 0", req_ready);
    end
    while (!resp_valid && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    checks++;
    if (cnt != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d want %0d (we=%b addr=%h size=%0d)", cnt, exp_lat, we, addr, size);
    end
    if (resp_valid && bp) begin
      held = resp_rdata;
      repeat (5) begin
        @(negedge clock);
        checks++;
        if ((resp_valid !== 1'b1) || (resp_rdata !== held) || (req_ready !== 1'b0) || mem_rd_en || mem_we_en) begin
          errors++;
          $display("FAIL backpressure_hold: valid=%b rdata=%h ready=%b rd=%b we=%b want 1 %h 0 0 0",
                   resp_valid, resp_rdata, req_ready, mem_rd_en, mem_we_en, held);
        end
      end
      resp_ready = 1'b1;
    end
    @(negedge clock);
    checks++;
    if ((req_ready !== 1'b1) || (resp_valid !== 1'b0)) begin
      errors++;
      $display("FAIL after_handshake: req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ((req_ready !== 1'b1) || (resp_valid !== 1'b0) || (resp_rdata !== 64'd0) || (mem_rd_en !== 1'b0) ||
        (mem_rd_addr !== 64'd0) || (mem_we_en !== 1'b0) || (mem_we_addr !== 64'd0) ||
        (mem_we_data !== 64'd0) || (mem_we_mask !== 8'h00)) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h rd=%b we=%b mask=%h", req_ready, resp_valid,
               resp_rdata, mem_rd_en, mem_we_en, mem_we_mask);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_load_byte();
    do_req(1'b0, 64'h8000_0007, 2'd0, 1'b1, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88);
    do_req(1'b0, 64'h8000_0007, 2'd0, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0000_0088);
    do_req(1'b0, 64'h8000_0000, 2'd3, 1'b1, 64'd0, 1'b0, 1'b1, 64'h8877_6655_4433_2211);
  endtask

  task automatic test_load_cross();
    do_req(1'b0, 64'h8000_0006, 2'd2, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0000_BBAA_8877);
    do_req(1'b0, 64'h8000_0006, 2'd2, 1'b1, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_BBAA_8877);
  endtask

  task automatic test_store_masks();
    for (int s = 0; s < 4; s++) begin
      do_req(1'b1, 64'h8000_0010, 2'(s), 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'd0);
      do_req(1'b0, 64'h8000_0010, 2'(s), 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    end
  endtask

  task automatic test_cross_store();
    do_req(1'b1, 64'h8000_001D, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'd0);
    do_req(1'b0, 64'h8000_001D, 2'd3, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 64'h8000_0003, 2'd1, 1'b1, 64'd0, 1'b1, 1'b1, 64'h0000_0000_0000_5544);
    do_req(1'b1, 64'h8000_0041, 2'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 64'd0);
  endtask

  task automatic test_reset_mid_store();
    logic [63:0] wd;
    wd = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 3; k++) begin
      exp_we.push_back({64'h8000_0031 + 64'(k), {56'b0, wd[8*k +: 8]}, 8'h01});
      ref_mem[8'(8'h31 + 8'(k))] = wd[8*k +: 8];
    end
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h8000_0031;
    req_size  = 2'd3;
    req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ((mem_we_en !== 1'b0) || (mem_we_mask !== 8'h00) || (req_ready !== 1'b1) || (resp_valid !== 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_store: we=%b mask=%h ready=%b valid=%b want 0 00 1 0",
               mem_we_en, mem_we_mask, req_ready, resp_valid);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if ((exp_we.size() != 0) || (exp_resp.size() != 0) || (req_ready !== 1'b1) || (resp_valid !== 1'b0)) begin
      errors++;
      $display("FAIL reset_release: pending_we=%0d pending_resp=%0d ready=%b valid=%b want 0 0 1 0",
               exp_we.size(), exp_resp.size(), req_ready, resp_valid);
    end
    exp_we.delete();
    // Readback confirms exactly beats 0..2 reached memory.
    do_req(1'b0, 64'h8000_0031, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_wrap();
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b0, 64'hA1B2_C3D4_E5F6_0718, 1'b0, 1'b0, 64'd0);
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b1, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      do_req(1'($urandom), 64'h8000_0000 + 64'($urandom_range(0, 255)), 2'($urandom), 1'($urandom),
             {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'b0, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) init_img[i] = 8'((i + 1) * 8'h11);
    init_img[8]  = 8'hAA;
    init_img[9]  = 8'hBB;
    init_img[10] = 8'hCC;
    init_img[11] = 8'hDD;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];
    load_img = 1'b1;
    @(posedge clock);
    @(negedge clock);
    load_img = 1'b0;

    test_reset();
    test_load_byte();
    test_load_cross();
    test_store_masks();
    test_cross_store();
    test_backpressure();
    test_reset_mid_store();
    test_wrap();
    test_back_to_back();

    repeat (3) @(negedge clock);
    checks++;
    if ((exp_we.size() != 0) || (exp_rd.size() != 0) || (exp_resp.size() != 0)) begin
      errors++;
      $display("FAIL scoreboard_drain: we=%0d rd=%0d resp=%0d left, want 0",
               exp_we.size(), exp_rd.size(), exp_resp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
